// File: rtl/load_ext_if.sv
// Load-extract handshake bundle: request side (in_*) and registered result side (out_*).
// master drives requests and out_ready; slave is the extractor pipe.
interface load_ext_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
);
    localparam int unsigned OffW = $clog2(DATA_W / 8);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OffW-1:0]   in_offset;
    logic [1:0]        in_size;
    logic              in_signed;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_data, in_offset, in_size, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_data, in_offset, in_size, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/load_ext_pipe.sv
// Load-data lane extractor with sign/zero extension, registered behind an output
// register plus one skid entry so in_ready never depends combinationally on out_ready.
module load_ext_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input logic       clk,
    input logic       rst_n,
    load_ext_if.slave bus
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic              err;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e state_q, state_d;
    entry_t or_q, sk_q, ext;
    logic   in_ready_q;
    logic   accept, emit;
    logic   or_load, or_from_sk, sk_load;

    logic [DATA_W-1:0] lane, keep;
    logic [3:0]        size_mask;
    logic              msb, misalign, illegal;

    // Extraction and extension happen before any register, so SK holds finished results.
    always_comb begin
        lane      = bus.in_data >> {bus.in_offset, 3'b000};
        size_mask = (4'd1 << bus.in_size) - 4'd1;
        misalign  = |(size_mask & 4'(bus.in_offset));
        illegal   = (bus.in_size == 2'd3) && (DATA_W == 32);
        keep      = '1;
        msb       = lane[DATA_W-1];
        case (bus.in_size)
            2'd0:    begin keep = DATA_W'(8'hFF);         msb = lane[7];  end
            2'd1:    begin keep = DATA_W'(16'hFFFF);      msb = lane[15]; end
            2'd2:    begin keep = DATA_W'(32'hFFFF_FFFF); msb = lane[31]; end
            default: ;
        endcase
        ext.tag = bus.in_tag;
        ext.err = misalign | illegal;
        if (ext.err) begin
            ext.data = '0;
        end else begin
            ext.data = (lane & keep) | ((bus.in_signed && msb) ? ~keep : '0);
        end
    end

    assign accept = bus.in_valid & in_ready_q;
    assign emit   = (state_q != StEmpty) & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StOne;
            StOne: begin
                if (accept && !emit)      state_d = StFull;
                else if (!accept && emit) state_d = StEmpty;
            end
            StFull:  if (emit) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        or_load    = 1'b0;
        or_from_sk = 1'b0;
        sk_load    = 1'b0;
        unique case (state_q)
            StEmpty: or_load = accept;
            StOne: begin
                or_load = accept & emit;
                sk_load = accept & ~emit;
            end
            StFull: begin
                or_load    = emit;
                or_from_sk = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q       <= '0;
            sk_q       <= '0;
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != StFull);
            if (or_load) or_q <= or_from_sk ? sk_q : ext;
            if (sk_load) sk_q <= ext;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != StEmpty);
    assign bus.out_data  = or_q.data;
    assign bus.out_tag   = or_q.tag;
    assign bus.out_err   = or_q.err;
endmodule

// File: tb/tb_load_ext_pipe.sv
// Directed and random checks of load_ext_pipe at DATA_W=32 and DATA_W=64, with a
// per-instance scoreboard fed on accept and drained on emit.
module tb_load_ext_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst32_n, rst64_n;

    load_ext_if #(.DATA_W(32), .TAG_W(5)) b32 ();
    load_ext_if #(.DATA_W(64), .TAG_W(5)) b64 ();

    load_ext_pipe #(.DATA_W(32), .TAG_W(5)) dut32 (.clk(clk), .rst_n(rst32_n), .bus(b32.slave));
    load_ext_pipe #(.DATA_W(64), .TAG_W(5)) dut64 (.clk(clk), .rst_n(rst64_n), .bus(b64.slave));

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc32    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int dw, input logic [63:0] d, input int off,
                                   input int size, input bit sgn, input logic [4:0] tag);
        exp_t        e;
        int          nb;
        logic [63:0] lane;
        logic        msb;
        nb    = 1 << size;
        e.tag = tag;
        e.err = 1'b0;
        e.data = '0;
        if ((size == 3 && dw == 32) || (off % nb) != 0) begin
            e.err = 1'b1;
            return e;
        end
        lane = d >> (8 * off);
        msb  = lane[8*nb-1];
        for (int i = 0; i < dw; i++) e.data[i] = (i < 8 * nb) ? lane[i] : (sgn & msb);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst32_n) begin
            if (b32.out_valid && b32.out_ready) begin
                chk("sb32_spurious", 64'(q32.size() == 0), 64'd0);
                if (q32.size() != 0) begin
                    exp_t e;
                    e = q32.pop_front();
                    chk("sb32_data", 64'(b32.out_data), e.data);
                    chk("sb32_tag", 64'(b32.out_tag), 64'(e.tag));
                    chk("sb32_err", 64'(b32.out_err), 64'(e.err));
                end
            end
            if (b32.in_valid && b32.in_ready) begin
                q32.push_back(model(32, 64'(b32.in_data), int'(b32.in_offset),
                                    int'(b32.in_size), b32.in_signed, b32.in_tag));
                acc32++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst64_n) begin
            if (b64.out_valid && b64.out_ready) begin
                chk("sb64_spurious", 64'(q64.size() == 0), 64'd0);
                if (q64.size() != 0) begin
                    exp_t e;
                    e = q64.pop_front();
                    chk("sb64_data", b64.out_data, e.data);
                    chk("sb64_tag", 64'(b64.out_tag), 64'(e.tag));
                    chk("sb64_err", 64'(b64.out_err), 64'(e.err));
                end
            end
            if (b64.in_valid && b64.in_ready) begin
                q64.push_back(model(64, b64.in_data, int'(b64.in_offset),
                                    int'(b64.in_size), b64.in_signed, b64.in_tag));
            end
        end
    end

    task automatic req32(input logic [1:0] off, input logic [1:0] sz, input logic sgn,
                         input logic [4:0] tag, input logic [31:0] ed, input logic ee,
                         input string nm);
        b32.in_valid  = 1'b1;
        b32.in_data   = 32'h8899_AABB;
        b32.in_offset = off;
        b32.in_size   = sz;
        b32.in_signed = sgn;
        b32.in_tag    = tag;
        @(posedge clk); #1;
        chk({nm, "_valid"}, 64'(b32.out_valid), 64'd1);
        chk({nm, "_data"}, 64'(b32.out_data), 64'(ed));
        chk({nm, "_tag"}, 64'(b32.out_tag), 64'(tag));
        chk({nm, "_err"}, 64'(b32.out_err), 64'(ee));
    endtask

    task automatic req64(input logic [2:0] off, input logic [1:0] sz, input logic sgn,
                         input logic [4:0] tag, input logic [63:0] ed, input string nm);
        b64.in_valid  = 1'b1;
        b64.in_data   = 64'h8000_0000_0000_0001;
        b64.in_offset = off;
        b64.in_size   = sz;
        b64.in_signed = sgn;
        b64.in_tag    = tag;
        @(posedge clk); #1;
        chk({nm, "_valid"}, 64'(b64.out_valid), 64'd1);
        chk({nm, "_data"}, b64.out_data, ed);
        chk({nm, "_err"}, 64'(b64.out_err), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc_start;
        rst32_n = 1'b0;
        rst64_n = 1'b0;
        b32.in_valid = 1'b0; b32.in_data = '0; b32.in_offset = '0; b32.in_size = '0;
        b32.in_signed = 1'b0; b32.in_tag = '0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.in_data = '0; b64.in_offset = '0; b64.in_size = '0;
        b64.in_signed = 1'b0; b64.in_tag = '0; b64.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_out_data", 64'(b32.out_data), 64'd0);
        chk("rst_out_tag", 64'(b32.out_tag), 64'd0);
        chk("rst_out_err", 64'(b32.out_err), 64'd0);
        #20;
        rst32_n = 1'b1;
        rst64_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
        chk("rst_idle_valid", 64'(b32.out_valid), 64'd0);

        // Extraction, back-to-back with out_ready high.
        req32(2'd1, 2'd0, 1'b1, 5'd1, 32'hFFFF_FFAA, 1'b0, "lb_off1");
        req32(2'd3, 2'd0, 1'b0, 5'd2, 32'h0000_0088, 1'b0, "lbu_off3");
        req32(2'd2, 2'd1, 1'b1, 5'd3, 32'hFFFF_8899, 1'b0, "lh_off2");
        req32(2'd0, 2'd1, 1'b0, 5'd4, 32'h0000_AABB, 1'b0, "lhu_off0");
        req32(2'd0, 2'd2, 1'b1, 5'd5, 32'h8899_AABB, 1'b0, "lw_off0");
        req32(2'd1, 2'd1, 1'b1, 5'd6, 32'h0, 1'b1, "lh_misalign");
        req32(2'd2, 2'd2, 1'b0, 5'd7, 32'h0, 1'b1, "lw_misalign");
        req32(2'd0, 2'd3, 1'b0, 5'd8, 32'h0, 1'b1, "size3_on32");
        b32.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drained_valid", 64'(b32.out_valid), 64'd0);

        // Backpressure: fill OR and SK, then release.
        b32.out_ready = 1'b0;
        b32.in_valid  = 1'b1; b32.in_offset = 2'd0; b32.in_size = 2'd2; b32.in_tag = 5'd1;
        @(posedge clk); #1;
        b32.in_tag = 5'd2;
        @(posedge clk); #1;
        chk("bp_full_in_ready", 64'(b32.in_ready), 64'd0);
        chk("bp_hold_tag1", 64'(b32.out_tag), 64'd1);
        b32.in_tag = 5'd3;
        @(posedge clk); #1;
        chk("bp_still_tag1", 64'(b32.out_tag), 64'd1);
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_tag2", 64'(b32.out_tag), 64'd2);
        chk("bp_ready_back", 64'(b32.in_ready), 64'd1);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        chk("bp_tag3_valid", 64'(b32.out_valid), 64'd1);
        chk("bp_tag3", 64'(b32.out_tag), 64'd3);
        @(posedge clk); #1;
        chk("bp_empty", 64'(b32.out_valid), 64'd0);

        // Random streaming with random backpressure.
        acc_start = acc32;
        for (int cyc = 0; cyc < 3000 && acc32 < acc_start + 100; cyc++) begin
            b32.in_valid  = 1'($urandom_range(0, 1));
            b32.in_data   = $urandom;
            b32.in_offset = 2'($urandom_range(0, 3));
            b32.in_size   = 2'($urandom_range(0, 3));
            b32.in_signed = 1'($urandom_range(0, 1));
            b32.in_tag    = 5'($urandom_range(0, 31));
            b32.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        chk("rand_accepted", 64'(acc32 - acc_start), 64'd100);
        b32.in_valid  = 1'b0;
        b32.out_ready = 1'b1;
        for (int i = 0; i < 10 && q32.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("rand_drained", 64'(q32.size()), 64'd0);

        // DATA_W=64 instance.
        req64(3'd0, 2'd3, 1'b0, 5'd9, 64'h8000_0000_0000_0001, "ld64_dword");
        req64(3'd4, 2'd2, 1'b1, 5'd10, 64'hFFFF_FFFF_8000_0000, "ld64_lw_off4");
        b64.in_valid  = 1'b0;
        b64.out_ready = 1'b0;
        @(posedge clk); #1;
        b64.in_valid = 1'b1; b64.in_tag = 5'd11;
        @(posedge clk); #1;
        b64.in_tag = 5'd12;
        @(posedge clk); #1;
        chk("ld64_full_in_ready", 64'(b64.in_ready), 64'd0);
        b64.in_valid = 1'b0;
        rst64_n = 1'b0;
        #1;
        chk("ld64_rst_valid", 64'(b64.out_valid), 64'd0);
        chk("ld64_rst_data", b64.out_data, 64'd0);
        q64.delete();
        #2;
        rst64_n = 1'b1;
        b64.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("ld64_post_rst_ready", 64'(b64.in_ready), 64'd1);
        chk("ld64_post_rst_valid", 64'(b64.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
